// File: rtl/planes_pkg.sv
// Shared types and defaults for the HUB75 plane scan sequencer.
package planes_pkg;

    localparam int unsigned COLS_DEF      = 64;
    localparam int unsigned ROWS_HALF_DEF = 32;
    localparam int unsigned PLANES_DEF    = 8;
    localparam int unsigned BASE_OE_DEF   = 4;

    typedef enum logic [2:0] {
        StIdle,
        StFetch0,
        StFetch1,
        StShiftLo,
        StShiftHi,
        StBlank,
        StLatch,
        StDisplay
    } scan_state_e;

    // Bit-angle modulation weight: plane p is shown base << p cycles.
    function automatic int unsigned oe_cycles(input int unsigned plane, input int unsigned base);
        return base << plane;
    endfunction

endpackage

// File: rtl/bcm_timer.sv
// Loadable down-counter timing the output-enable window of one bit-plane.
module bcm_timer #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/planes_scan_ctrl.sv
// HUB75 scan sequencer: fetches two plane words per row pair, shifts them out,
// latches the row and holds output-enable for a binary-weighted time.
module planes_scan_ctrl
    import planes_pkg::*;
#(
    parameter int unsigned COLS      = COLS_DEF,
    parameter int unsigned ROWS_HALF = ROWS_HALF_DEF,
    parameter int unsigned PLANES    = PLANES_DEF,
    parameter int unsigned BASE_OE   = BASE_OE_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_EN,
    output logic                         out_REQ,
    output logic                         out_HALF,
    output logic [$clog2(ROWS_HALF)-1:0] out_ROW,
    output logic [$clog2(PLANES)-1:0]    out_PLANE,
    input  logic                         in_VALID,
    output logic                         out_LOAD0,
    output logic                         out_LOAD1,
    output logic                         out_SHIFT,
    output logic                         out_PCLK,
    output logic                         out_LAT,
    output logic                         out_OE_n,
    output logic [$clog2(ROWS_HALF)-1:0] out_ADDR,
    output logic                         out_FRAME
);

    localparam int unsigned RW = $clog2(ROWS_HALF);
    localparam int unsigned PW = $clog2(PLANES);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned TW = $clog2(BASE_OE << (PLANES - 1)) + 1;

    scan_state_e   state_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [PW-1:0] plane_q;
    logic          pclk_q;
    logic          lat_q;
    logic          oe_n_q;
    logic [RW-1:0] addr_q;
    logic          frame_q;

    logic          timer_load;
    logic          timer_dec;
    logic [TW-1:0] timer_val;
    logic          timer_done;

    // Loaded with weight-1 so DISPLAY lasts exactly the weight in cycles.
    always_comb begin
        timer_load = (state_q == StLatch);
        timer_dec  = (state_q == StDisplay);
        timer_val  = TW'(oe_cycles(32'(plane_q), BASE_OE) - 32'd1);
    end

    bcm_timer #(
        .WIDTH (TW)
    ) u_bcm_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .dec      (timer_dec),
        .done     (timer_done)
    );

    // Registered panel outputs are set on the transition into the state that owns them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            plane_q <= '0;
            pclk_q  <= 1'b0;
            lat_q   <= 1'b0;
            oe_n_q  <= 1'b1;
            addr_q  <= '0;
            frame_q <= 1'b0;
        end else begin
            lat_q   <= 1'b0;
            frame_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_EN) state_q <= StFetch0;
                end
                StFetch0: begin
                    if (in_VALID) state_q <= StFetch1;
                end
                StFetch1: begin
                    if (in_VALID) begin
                        state_q <= StShiftLo;
                        col_q   <= '0;
                    end
                end
                StShiftLo: begin
                    state_q <= StShiftHi;
                    pclk_q  <= 1'b1;
                end
                StShiftHi: begin
                    pclk_q <= 1'b0;
                    if (col_q == CW'(COLS - 1)) begin
                        state_q <= StBlank;
                        addr_q  <= row_q;
                    end else begin
                        col_q   <= col_q + 1'b1;
                        state_q <= StShiftLo;
                    end
                end
                StBlank: begin
                    state_q <= StLatch;
                    lat_q   <= 1'b1;
                end
                StLatch: begin
                    state_q <= StDisplay;
                    oe_n_q  <= 1'b0;
                end
                StDisplay: begin
                    if (timer_done) begin
                        oe_n_q  <= 1'b1;
                        state_q <= in_EN ? StFetch0 : StIdle;
                        if (plane_q == PW'(PLANES - 1)) begin
                            plane_q <= '0;
                            if (row_q == RW'(ROWS_HALF - 1)) begin
                                row_q   <= '0;
                                frame_q <= 1'b1;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            plane_q <= plane_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    oe_n_q  <= 1'b1;
                end
            endcase
        end
    end

    // Cache controls are gated by reset so a reset cycle never issues a partial load.
    always_comb begin
        out_REQ   = 1'b0;
        out_HALF  = 1'b0;
        out_LOAD0 = 1'b0;
        out_LOAD1 = 1'b0;
        out_SHIFT = 1'b0;
        if (rst_n) begin
            out_REQ   = (state_q == StFetch0) || (state_q == StFetch1);
            out_HALF  = (state_q == StFetch1);
            out_LOAD0 = (state_q == StFetch0) && in_VALID;
            out_LOAD1 = (state_q == StFetch1) && in_VALID;
            out_SHIFT = (state_q == StShiftHi);
        end
        out_ROW   = row_q;
        out_PLANE = plane_q;
        out_PCLK  = pclk_q;
        out_LAT   = lat_q;
        out_OE_n  = oe_n_q;
        out_ADDR  = addr_q;
        out_FRAME = frame_q;
    end

endmodule

// File: tb/tb_planes_scan_ctrl.sv
// Randomized bench for planes_scan_ctrl: per-plane records checked against scan-rule arithmetic.
module tb_planes_scan_ctrl;

    localparam int COLS = 64, ROWS_HALF = 32, PLANES = 8, BASE_OE = 4;
    localparam int S_COLS = 4, S_ROWS = 2, S_PLANES = 2, S_BASE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, in_EN, in_VALID;
    logic       out_REQ, out_HALF, out_LOAD0, out_LOAD1, out_SHIFT;
    logic       out_PCLK, out_LAT, out_OE_n, out_FRAME;
    logic [4:0] out_ROW, out_ADDR;
    logic [2:0] out_PLANE;

    logic s_EN, s_VALID, s_REQ, s_HALF, s_LOAD0, s_LOAD1, s_SHIFT;
    logic s_PCLK, s_LAT, s_OE_n, s_FRAME;
    logic [0:0] s_ROW, s_PLANE, s_ADDR;

    planes_scan_ctrl #(
        .COLS (COLS), .ROWS_HALF (ROWS_HALF), .PLANES (PLANES), .BASE_OE (BASE_OE)
    ) dut (
        .clk (clk), .rst_n (rst_n), .in_EN (in_EN), .out_REQ (out_REQ), .out_HALF (out_HALF),
        .out_ROW (out_ROW), .out_PLANE (out_PLANE), .in_VALID (in_VALID),
        .out_LOAD0 (out_LOAD0), .out_LOAD1 (out_LOAD1), .out_SHIFT (out_SHIFT),
        .out_PCLK (out_PCLK), .out_LAT (out_LAT), .out_OE_n (out_OE_n),
        .out_ADDR (out_ADDR), .out_FRAME (out_FRAME)
    );

    planes_scan_ctrl #(
        .COLS (S_COLS), .ROWS_HALF (S_ROWS), .PLANES (S_PLANES), .BASE_OE (S_BASE)
    ) dut_small (
        .clk (clk), .rst_n (rst_n), .in_EN (s_EN), .out_REQ (s_REQ), .out_HALF (s_HALF),
        .out_ROW (s_ROW), .out_PLANE (s_PLANE), .in_VALID (s_VALID),
        .out_LOAD0 (s_LOAD0), .out_LOAD1 (s_LOAD1), .out_SHIFT (s_SHIFT),
        .out_PCLK (s_PCLK), .out_LAT (s_LAT), .out_OE_n (s_OE_n),
        .out_ADDR (s_ADDR), .out_FRAME (s_FRAME)
    );

    typedef struct {
        int row, plane, f0, f1, load0, load1, shifts, shift_pclk, pclk_hi, lat;
        int oe_low, addr, cycles, frame, req_bad, bad;
    } rec_t;

    rec_t rec_q[$];
    int   wq0[$], wq1[$];
    int   n_pass = 0, n_total = 0;
    int   plane_idx;
    bit   rand_waits;
    int   fix_w0, fix_w1;

    // Memory model: answers each request after a chosen number of wait cycles.
    initial begin
        int wcnt, w0, w1;
        bit prev_req;
        in_VALID = 1'b0; wcnt = 0; w0 = 0; w1 = 0; prev_req = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (out_REQ === 1'b1) begin
                if (!out_HALF && !prev_req) begin
                    if (rand_waits) begin
                        w0 = $urandom_range(0, 3); w1 = $urandom_range(0, 3);
                    end else begin
                        w0 = fix_w0; w1 = fix_w1;
                    end
                    wq0.push_back(w0); wq1.push_back(w1); wcnt = 0;
                end
                in_VALID = (wcnt >= (out_HALF ? w1 : w0));
                wcnt = in_VALID ? 0 : wcnt + 1;
            end else begin
                in_VALID = 1'($urandom_range(0, 1));
                wcnt = 0;
            end
            prev_req = (out_REQ === 1'b1);
        end
    end

    // Observer: one record per plane, closed on the first cycle OE returns high.
    initial begin
        rec_t cur;
        bit active, oe_seen, prev_req, prev_half, prev_oe_n;
        int prev_addr;
        cur = '{default: 0}; active = 0; oe_seen = 0;
        prev_req = 0; prev_half = 0; prev_oe_n = 1; prev_addr = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                active = 0; oe_seen = 0; cur = '{default: 0};
            end else begin
                if (oe_seen && out_OE_n) begin
                    cur.frame = int'(out_FRAME);
                    rec_q.push_back(cur);
                    cur = '{default: 0}; active = 0; oe_seen = 0;
                end
                if (!active && out_REQ) begin
                    active = 1; cur.row = int'(out_ROW); cur.plane = int'(out_PLANE);
                end
                if (active) begin
                    cur.cycles++;
                    if (out_REQ && !out_HALF) cur.f0++;
                    if (out_REQ && out_HALF) cur.f1++;
                    if (out_REQ && (int'(out_ROW) != cur.row || int'(out_PLANE) != cur.plane))
                        cur.req_bad++;
                    if (out_REQ && prev_req && prev_half && !out_HALF) cur.req_bad++;
                    cur.load0 += int'(out_LOAD0);
                    cur.load1 += int'(out_LOAD1);
                    cur.shifts += int'(out_SHIFT);
                    cur.shift_pclk += int'(out_SHIFT && out_PCLK);
                    cur.pclk_hi += int'(out_PCLK);
                    cur.lat += int'(out_LAT);
                    if (int'(out_LOAD0) + int'(out_LOAD1) + int'(out_SHIFT) > 1) cur.bad++;
                    if (!out_OE_n) begin
                        cur.oe_low++; oe_seen = 1; cur.addr = int'(out_ADDR);
                        if (out_LAT || out_REQ || out_PCLK) cur.bad++;
                    end
                    if (int'(out_ADDR) != prev_addr && (!out_OE_n || !prev_oe_n)) cur.bad++;
                end
            end
            prev_req = out_REQ; prev_half = out_HALF;
            prev_oe_n = out_OE_n; prev_addr = int'(out_ADDR);
        end
    end

    task automatic wait_rec(output rec_t r, output int w0, output int w1, output bit ok);
        ok = 0; w0 = -1; w1 = -1; r = '{default: 0};
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (rec_q.size() > 0) begin
                r = rec_q.pop_front();
                if (wq0.size() > 0) begin w0 = wq0.pop_front(); w1 = wq1.pop_front(); end
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int req_hi, oe_lo;
        rst_n = 1'b0; in_EN = 1'b0; s_EN = 1'b0; s_VALID = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (out_OE_n !== 1'b1) $display("FAIL reset_oe_n: got %b expected 1", out_OE_n);
        else n_pass++;
        n_total++;
        if ({out_REQ, out_HALF, out_LOAD0, out_LOAD1, out_SHIFT, out_PCLK, out_LAT, out_FRAME,
             out_ADDR, out_ROW, out_PLANE} !== 21'd0)
            $display("FAIL reset_outputs: got nonzero outputs expected all 0");
        else n_pass++;
        @(posedge clk); #2 rst_n = 1'b1;
        req_hi = 0; oe_lo = 0;
        repeat (20) begin
            @(negedge clk);
            req_hi += int'(out_REQ !== 1'b0);
            oe_lo += int'(out_OE_n !== 1'b1);
        end
        n_total++;
        if (req_hi !== 0) $display("FAIL idle_req: got %0d cycles expected 0", req_hi);
        else n_pass++;
        n_total++;
        if (oe_lo !== 0) $display("FAIL idle_oe: got %0d low cycles expected 0", oe_lo);
        else n_pass++;
    endtask

    task automatic test_zero_wait;
        rec_t r; int w0, w1; bit ok;
        rand_waits = 0; fix_w0 = 0; fix_w1 = 0;
        rec_q.delete(); wq0.delete(); wq1.delete(); plane_idx = 0;
        @(posedge clk); #2 in_EN = 1'b1;
        wait_rec(r, w0, w1, ok);
        n_total++;
        if (!ok) begin $display("FAIL zw_timeout: got no plane expected one"); return; end
        n_pass++;
        n_total++;
        if (r.f0 !== 1 || r.f1 !== 1) $display("FAIL zw_fetch: got %0d/%0d expected 1/1", r.f0, r.f1);
        else n_pass++;
        n_total++;
        if (r.load0 !== 1 || r.load1 !== 1)
            $display("FAIL zw_loads: got %0d/%0d expected 1/1", r.load0, r.load1);
        else n_pass++;
        n_total++;
        if (r.shifts !== COLS) $display("FAIL zw_shifts: got %0d expected %0d", r.shifts, COLS);
        else n_pass++;
        n_total++;
        if (r.shift_pclk !== COLS || r.pclk_hi !== COLS)
            $display("FAIL zw_pclk: got %0d/%0d expected %0d", r.shift_pclk, r.pclk_hi, COLS);
        else n_pass++;
        n_total++;
        if (r.lat !== 1) $display("FAIL zw_lat: got %0d expected 1", r.lat);
        else n_pass++;
        n_total++;
        if (r.oe_low !== BASE_OE) $display("FAIL zw_oe: got %0d expected %0d", r.oe_low, BASE_OE);
        else n_pass++;
        n_total++;
        if (r.cycles !== 136) $display("FAIL zw_cycles: got %0d expected 136", r.cycles);
        else n_pass++;
        n_total++;
        if (r.row !== 0 || r.plane !== 0 || r.bad !== 0 || r.req_bad !== 0)
            $display("FAIL zw_misc: got row %0d plane %0d bad %0d/%0d expected 0",
                     r.row, r.plane, r.bad, r.req_bad);
        else n_pass++;
        plane_idx++;
    endtask

    task automatic test_plane_weighting;
        rec_t r; int w0, w1, ep, er, n; bit ok;
        rand_waits = 1;
        for (int k = 0; k < 9; k++) begin
            wait_rec(r, w0, w1, ok);
            n_total++;
            if (!ok) begin $display("FAIL pw_timeout: got no plane %0d", k); return; end
            n_pass++;
            ep = plane_idx % PLANES; er = (plane_idx / PLANES) % ROWS_HALF; n = BASE_OE << ep;
            n_total++;
            if (r.row !== er || r.plane !== ep)
                $display("FAIL pw_req: got %0d/%0d expected %0d/%0d", r.row, r.plane, er, ep);
            else n_pass++;
            n_total++;
            if (r.oe_low !== n) $display("FAIL pw_oe p%0d: got %0d expected %0d", ep, r.oe_low, n);
            else n_pass++;
            n_total++;
            if (r.addr !== er) $display("FAIL pw_addr: got %0d expected %0d", r.addr, er);
            else n_pass++;
            n_total++;
            if (r.f0 !== w0 + 1 || r.f1 !== w1 + 1)
                $display("FAIL pw_wait: got %0d/%0d expected %0d/%0d", r.f0, r.f1, w0 + 1, w1 + 1);
            else n_pass++;
            n_total++;
            if (r.cycles !== w0 + w1 + 2 + 2 * COLS + 2 + n)
                $display("FAIL pw_cycles: got %0d expected %0d", r.cycles, w0 + w1 + 4 + 2 * COLS + n);
            else n_pass++;
            n_total++;
            if (r.shifts !== COLS || r.lat !== 1 || r.frame !== 0 || r.bad !== 0 || r.req_bad !== 0)
                $display("FAIL pw_shape: got sh %0d lat %0d fr %0d bad %0d/%0d expected %0d 1 0 0/0",
                         r.shifts, r.lat, r.frame, r.bad, r.req_bad, COLS);
            else n_pass++;
            plane_idx++;
        end
    endtask

    task automatic test_stall;
        rec_t r; int w0, w1, n; bit ok;
        rand_waits = 0; fix_w0 = 0; fix_w1 = 5;
        for (int k = 0; k < 2; k++) begin
            wait_rec(r, w0, w1, ok);
            n_total++;
            if (!ok) begin $display("FAIL st_timeout: got no plane %0d", k); return; end
            n_pass++;
            n = BASE_OE << (plane_idx % PLANES);
            plane_idx++;
        end
        n_total++;
        if (r.f1 !== 6 || r.f0 !== 1) $display("FAIL st_fetch: got %0d/%0d expected 1/6", r.f0, r.f1);
        else n_pass++;
        n_total++;
        if (r.load0 !== 1 || r.load1 !== 1)
            $display("FAIL st_loads: got %0d/%0d expected 1/1", r.load0, r.load1);
        else n_pass++;
        n_total++;
        if (r.req_bad !== 0) $display("FAIL st_req_stable: got %0d changes expected 0", r.req_bad);
        else n_pass++;
        n_total++;
        if (r.cycles !== 7 + 2 * COLS + 2 + n)
            $display("FAIL st_cycles: got %0d expected %0d", r.cycles, 7 + 2 * COLS + 2 + n);
        else n_pass++;
    endtask

    task automatic test_en_drop;
        rec_t r; int w0, w1, n, req_hi, oe_lo; bit ok, seen;
        rand_waits = 1; seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            seen = (out_SHIFT === 1'b1);
        end
        n_total++;
        if (!seen) begin $display("FAIL en_shift_timeout: got no shift expected shift"); return; end
        n_pass++;
        @(posedge clk); #2 in_EN = 1'b0;
        wait_rec(r, w0, w1, ok);
        n = BASE_OE << (plane_idx % PLANES);
        n_total++;
        if (!ok || r.oe_low !== n || r.shifts !== COLS)
            $display("FAIL en_complete: got ok %0d oe %0d sh %0d expected 1 %0d %0d",
                     ok, r.oe_low, r.shifts, n, COLS);
        else n_pass++;
        plane_idx++;
        req_hi = 0; oe_lo = 0;
        repeat (30) begin
            @(negedge clk);
            req_hi += int'(out_REQ !== 1'b0);
            oe_lo += int'(out_OE_n !== 1'b1);
        end
        n_total++;
        if (req_hi !== 0 || oe_lo !== 0)
            $display("FAIL en_idle: got req %0d oe_low %0d expected 0 0", req_hi, oe_lo);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        rec_t r; int w0, w1; bit ok, seen;
        seen = 0;
        @(posedge clk); #2 in_EN = 1'b1;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            seen = (out_OE_n === 1'b0);
        end
        n_total++;
        if (!seen) begin $display("FAIL rm_display_timeout: got no OE expected OE"); return; end
        n_pass++;
        @(posedge clk); #2 rst_n = 1'b0;
        @(negedge clk);
        n_total++;
        if (out_LOAD0 !== 1'b0 || out_LOAD1 !== 1'b0)
            $display("FAIL rm_no_load: got %b%b expected 00", out_LOAD0, out_LOAD1);
        else n_pass++;
        @(posedge clk); #2;
        rec_q.delete(); wq0.delete(); wq1.delete(); plane_idx = 0;
        @(negedge clk);
        n_total++;
        if (out_OE_n !== 1'b1) $display("FAIL rm_oe_n: got %b expected 1", out_OE_n);
        else n_pass++;
        n_total++;
        if ({out_REQ, out_LOAD0, out_LOAD1, out_SHIFT, out_PCLK, out_LAT, out_ROW, out_PLANE,
             out_ADDR} !== 19'd0)
            $display("FAIL rm_outputs: got nonzero expected all 0");
        else n_pass++;
        @(posedge clk); #2 rst_n = 1'b1;
        wait_rec(r, w0, w1, ok);
        n_total++;
        if (!ok || r.row !== 0 || r.plane !== 0 || r.oe_low !== BASE_OE)
            $display("FAIL rm_restart: got ok %0d row %0d plane %0d oe %0d expected 1 0 0 %0d",
                     ok, r.row, r.plane, r.oe_low, BASE_OE);
        else n_pass++;
        in_EN = 1'b0;
    endtask

    task automatic test_frame;
        int sc[$], sr[$], sp[$], fr[$];
        bit prev;
        prev = 0;
        s_VALID = 1'b1;
        @(posedge clk); #2 s_EN = 1'b1;
        for (int cyc = 0; cyc < 600 && sc.size() < 9; cyc++) begin
            @(negedge clk);
            if (s_REQ && !s_HALF && !prev) begin
                sc.push_back(cyc); sr.push_back(int'(s_ROW)); sp.push_back(int'(s_PLANE));
            end
            if (s_FRAME) fr.push_back(cyc);
            prev = s_REQ;
        end
        s_EN = 1'b0;
        n_total++;
        if (sc.size() !== 9) begin
            $display("FAIL fr_timeout: got %0d planes expected 9", sc.size());
            return;
        end
        n_pass++;
        for (int k = 0; k < 9; k++) begin
            n_total++;
            if (sr[k] !== (k / S_PLANES) % S_ROWS || sp[k] !== k % S_PLANES)
                $display("FAIL fr_seq %0d: got %0d/%0d expected %0d/%0d",
                         k, sr[k], sp[k], (k / S_PLANES) % S_ROWS, k % S_PLANES);
            else n_pass++;
        end
        for (int k = 0; k < 8; k++) begin
            n_total++;
            if (sc[k + 1] - sc[k] !== 2 + 2 * S_COLS + 2 + (S_BASE << (k % S_PLANES)))
                $display("FAIL fr_len %0d: got %0d expected %0d", k, sc[k + 1] - sc[k],
                         2 + 2 * S_COLS + 2 + (S_BASE << (k % S_PLANES)));
            else n_pass++;
        end
        n_total++;
        if (fr.size() !== 2) $display("FAIL fr_count: got %0d expected 2", fr.size());
        else n_pass++;
        if (fr.size() == 2) begin
            n_total++;
            if (fr[0] !== sc[4] || fr[1] !== sc[8])
                $display("FAIL fr_pos: got %0d,%0d expected %0d,%0d", fr[0], fr[1], sc[4], sc[8]);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_EN = 1'b0; s_EN = 1'b0; s_VALID = 1'b0;
        rand_waits = 0; fix_w0 = 0; fix_w1 = 0; plane_idx = 0;
        test_reset;
        test_zero_wait;
        test_plane_weighting;
        test_stall;
        test_en_drop;
        test_reset_mid;
        test_frame;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/planes_scan_ctrl.md
# planes_scan_ctrl

Sequencer that drives the HUB75 panel scan and is the initiator for `planes_cache`. For each row pair and bit-plane it fetches two 64-bit RGB plane words from frame memory and steers them into the cache with `out_LOAD0`/`out_LOAD1`. It then issues 64 `out_SHIFT` pulses in lock-step with the panel clock, latches the row, and holds output-enable for a binary-weighted time (bit-angle modulation). It sits between the frame-memory read port and the panel pins, alongside `planes_cache`.

## Interface
Parameters:
- `COLS`, 64: columns per row; equals the cache width.
- `ROWS_HALF`, 32: row pairs per frame; `out_ADDR` width is clog2(ROWS_HALF).
- `PLANES`, 8: bit-planes per colour.
- `BASE_OE`, 4: display cycles for plane 0; plane p displays BASE_OE<<p cycles.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_EN`  in  1  run enable.
- `out_REQ`  out  1  frame-memory read request, held until `in_VALID`.
- `out_HALF`  out  1  0 = upper row (cache set 0), 1 = lower row (set 1).
- `out_ROW`  out  clog2(ROWS_HALF)  row index of the request.
- `out_PLANE`  out  clog2(PLANES)  plane index of the request.
- `in_VALID`  in  1  memory is presenting the requested word on the cache `in_R/G/B` this cycle.
- `out_LOAD0`, `out_LOAD1`, `out_SHIFT`  out  1 each  cache controls.
- `out_PCLK`  out  1  panel shift clock.
- `out_LAT`  out  1  panel latch, active high.
- `out_OE_n`  out  1  panel output enable, active low.
- `out_ADDR`  out  clog2(ROWS_HALF)  panel row-select lines.
- `out_FRAME`  out  1  one-cycle pulse at end of frame.

## Operation
- States: IDLE, FETCH0, FETCH1, SHIFT_LO, SHIFT_HI, BLANK, LATCH, DISPLAY.
- IDLE: leave when `in_EN`=1; go to FETCH0 with the current row/plane.
- FETCH0:
  - `out_REQ`=1, `out_HALF`=0.
  - On `in_VALID`, `out_LOAD0`=in_VALID combinationally in the same cycle, then go to FETCH1.
- FETCH1: same, with `out_HALF`=1 and `out_LOAD1`; then go to SHIFT_LO with column count 0.
- SHIFT_LO: `out_PCLK`=0; the cache presents column data. Go to SHIFT_HI.
- SHIFT_HI:
  - `out_PCLK`=1 and `out_SHIFT`=1, so the cache advances on the edge that ends PCLK-high.
  - If col==COLS-1, go to BLANK; otherwise col++ and go to SHIFT_LO.
- BLANK: `out_OE_n`=1; `out_ADDR` takes the current row. Go to LATCH.
- LATCH: `out_LAT`=1 for one cycle. Go to DISPLAY and load the timer with BASE_OE<<plane.
- DISPLAY:
  - `out_OE_n`=0 until the timer reaches 0.
  - Then advance: plane++. When the plane wraps from PLANES-1 to 0, row++. When the row wraps from ROWS_HALF-1 to 0, pulse `out_FRAME`.
  - Next state is FETCH0 if `in_EN`, else IDLE.
- `in_EN` is sampled only in IDLE and at DISPLAY exit; deassertion mid-row completes the current plane.
- `out_LOAD0`/`out_LOAD1`/`out_SHIFT` are mutually exclusive by construction.
- `in_VALID` outside FETCH states is ignored.

## Timing
- Reset:
  - state IDLE; row, plane and column counters 0.
  - `out_OE_n`=1; every other output 0.
- Registered outputs: `out_PCLK`, `out_LAT`, `out_OE_n`, `out_ADDR`, `out_FRAME`.
- Combinational outputs: the request fields and LOAD/SHIFT, decoded from state.
- Cycles per plane, with zero-wait memory (`in_VALID` in the first FETCH cycle): 2 + 2·COLS + 1 + 1 + (BASE_OE<<p). For p=0 with defaults this is 136 cycles.
- Memory wait states extend FETCH0/FETCH1 indefinitely. `out_REQ` and its address stay stable during the wait.
- `out_OE_n` is high in every state except DISPLAY.
- `out_ADDR` changes only in BLANK, never while OE is active.
- Timer width: clog2(BASE_OE<<(PLANES-1))+1.
- Reset mid-operation: the next cycle is IDLE with reset outputs, the panel is blanked, and no partial LOAD is issued.

## Structure
- Package `planes_pkg`:
  - state enum encoding.
  - COLS/ROWS_HALF/PLANES defaults.
  - helper function `oe_cycles(plane)`.
- Sub-module `bcm_timer`: loadable down-counter with a `done` flag, used for DISPLAY.
- Top-level: FSM plus column/row/plane counters.

## Test plan
- Reset held for 3 cycles, then released with `in_EN`=0: `out_OE_n`=1, all else 0, `out_REQ` never rises.
- Zero-wait memory: `out_LOAD0` and `out_LOAD1` in cycles 1–2. Then exactly 64 `out_SHIFT` pulses, each coinciding with `out_PCLK`=1. One `out_LAT`, then `out_OE_n`=0 for exactly 4 cycles for plane 0.
- Plane weighting: measured OE-low lengths are 4, 8, 16, …, 512 for planes 0–7. After plane 7, `out_ADDR` increments by 1 during BLANK.
- Memory stalls `in_VALID` for 5 cycles in FETCH1: `out_REQ`=1 and `out_HALF`=1 held stable throughout, `out_LOAD1` on the valid cycle only, and no `out_LOAD0` re-issue.
- Full frame with ROWS_HALF=2, PLANES=2: `out_FRAME` pulses once after row 1 plane 1, and row/plane wrap to 0.
- `in_EN` dropped mid-SHIFT: the current plane completes its DISPLAY, then IDLE with `out_OE_n`=1. Assert `rst_n`=0 mid-DISPLAY: the next cycle is `out_OE_n`=1 with counters at 0.
